qencoder_gen: RTL and testbench
===============================

// Module: qencoder_gen
// PURPOSE
//  Quadrature encoder signal generator: drives A/B encoder lines so that a position counter tracks a commanded target.
//  - Emits one Gray-coded step at a time, at a programmable rate, until o_position equals the target.
//  - Used as a motor/encoder emulator in loopback with the quadrature decoder (A/B to position) in PL test designs.
// PARAMETERS
//  NB        32   width of position/target (two's complement, modular)
//  PW        16   width of step-period register
//  CPR_LOG2  10   log2(counts per revolution); used only with QGEN_INDEX_EN
// PORTS
//  clk         in   1     system clock
//  i_reset     in   1     asynchronous, active-low reset
//  i_enable    in   1     run enable; low freezes the block
//  i_target    in   NB    target position, sampled on i_load
//  i_load      in   1     1-cycle strobe: capture i_target
//  i_period    in   PW    clk cycles per step; 0 is treated as 1
//  o_encoder   out  2     {A,B} quadrature outputs, registered
//  o_position  out  NB    generated position (steps emitted, signed sum)
//  o_dir       out  1     1 = last step forward (+1), 0 = reverse
//  o_busy      out  1     high while o_position != captured target
//  o_done      out  1     1-cycle pulse when o_position reaches target
//  o_index     out  1     index pulse (QGEN_INDEX_EN only)
// BEHAVIOUR
//  Reset: o_encoder=2'b00, o_position=0, o_dir=0, o_busy=0, o_done=0, o_index=0, target=0, prescaler=0, state IDLE.
//  Gray sequence:
//  - Forward (+1): 00->10->11->01->00.
//  - Reverse (-1): 00->01->11->10->00.
//  - Exactly one bit of o_encoder changes per step; o_encoder never changes except on a step.
//  - Phase is always derived from o_position[1:0] (0:00, 1:10, 2:11, 3:01), so the output phase is locked to the count.
//  FSM:
//  - IDLE: o_busy=0, prescaler held at 0. If the target register != o_position and i_enable=1, go to RUN.
//  - RUN: prescaler counts 0..max(i_period,1)-1. At the terminal count:
//    - Emit one step; o_position and o_encoder update in the same cycle.
//    - Prescaler returns to 0.
//    - If the new position == target: pulse o_done next to the step edge (same cycle as the final update), then go to IDLE.
//  - Busy flag: o_busy = (state==RUN), registered.
//  - Latency: the first step occurs exactly max(i_period,1) cycles after entering RUN. Entry to RUN happens 1 cycle after i_load.
//  Direction:
//  - diff = target - o_position (NB-bit modular). Forward if diff[NB-1]==0, else reverse. This is the shortest modular path.
//  - Ties at 2^(NB-1) go reverse.
//  - Direction is re-evaluated at every step. o_dir is updated only on a step.
//  Boundaries:
//  - i_load while RUN: the target is replaced and the prescaler is not reset. The next step uses the new direction. If the new target equals the current position: go to IDLE with no step and no o_done.
//  - i_load with target == o_position in IDLE: no step, o_done not pulsed.
//  - i_period changed mid-run: takes effect at the next prescaler comparison. If the prescaler is already >= the new period-1, the step fires on the next cycle.
//  - Position wrap: 2^NB-1 +1 -> 0 and 0 -1 -> 2^NB-1. The Gray sequence stays continuous across the wrap.
//  - i_enable=0: all state, prescaler, outputs and target held; o_done forced 0. i_load is still captured.
//  - i_reset asserted mid-step: immediate return to reset values, and o_encoder goes to 00 asynchronously.
// CONFIGURATION
//  QGEN_INDEX_EN defined:
//  - o_index = 1 (registered) while o_position[CPR_LOG2-1:0]==0, in both directions. This gives one index per revolution.
//  QGEN_INDEX_EN undefined:
//  - o_index is tied to 0 and no index logic is generated. The port is still present.
// TESTING
//  - Reset: hold i_reset=0 for 3 clk -> o_encoder=00, o_position=0, o_busy=0, o_done=0.
//  - Forward move: period=4, load target=5.
//    - o_encoder steps 10,11,01,00,10 at cycles 5,9,13,17,21 after the load.
//    - o_position goes 1..5, o_dir=1, o_done pulses once at cycle 21, then o_busy=0.
//  - Reverse and wrap: from 0, period=1, load target=-3 (0xFFFFFFFD).
//    - o_encoder goes 01,11,10 on consecutive cycles; o_position = FFFFFFFF, FFFFFFFE, FFFFFFFD; o_dir=0.
//  - Retarget: period=8, target=100; at position 3 load target=1.
//    - Direction reverses on the next step; positions go 2,1; a single o_done pulse.
//  - Enable freeze: drop i_enable for 20 cycles mid-move.
//    - o_encoder, o_position and the prescaler are unchanged; the move resumes with the remaining prescaler count.
//  - Loopback: connect o_encoder to the decoder; random targets and periods over 10k cycles.
//    - Decoder position == o_position at all times.
//    - With QGEN_INDEX_EN, CPR_LOG2=2: o_index is high at positions 0,4,8,...

Source files
------------

// File: rtl/qencoder_gen.sv
// -----------------------------------------------------------------------------
// qencoder_gen -- quadrature encoder signal generator
//
// Drives A/B quadrature lines one Gray-coded step at a time, at a programmable
// rate, until the emitted position equals a commanded target. Used as a
// motor/encoder emulator looped back into a quadrature decoder.
//
// Ports
//   clk         in   1    system clock
//   i_reset     in   1    asynchronous, active-low reset
//   i_enable    in   1    run enable; low freezes all state (loads still captured)
//   i_target    in   NB   target position, captured on i_load
//   i_load      in   1    1-cycle strobe: capture i_target
//   i_period    in   PW   clk cycles per step; 0 behaves as 1
//   o_encoder   out  2    {A,B}, registered, phase locked to o_position[1:0]
//   o_position  out  NB   signed modular sum of emitted steps
//   o_dir       out  1    direction of the last step (1 = +1)
//   o_busy      out  1    high while a move is in progress
//   o_done      out  1    1-cycle pulse on the step that reaches the target
//   o_index     out  1    index pulse, once per revolution
//
// Configuration macro
//   QGEN_INDEX_EN  when defined, o_index is high (registered) while
//                  o_position[CPR_LOG2-1:0] == 0; otherwise o_index is tied 0.
// -----------------------------------------------------------------------------
module qencoder_gen #(
    parameter int NB       = 32,
    parameter int PW       = 16,
    parameter int CPR_LOG2 = 10
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic [NB-1:0] i_target,
    input  logic          i_load,
    input  logic [PW-1:0] i_period,
    output logic [1:0]    o_encoder,
    output logic [NB-1:0] o_position,
    output logic          o_dir,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_index
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q,  state_d;
    logic [NB-1:0] target_q, target_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [NB-1:0] pos_q,    pos_d;
    logic [1:0]    enc_q,    enc_d;
    logic          dir_q,    dir_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    logic [PW-1:0] period_eff_s;
    logic [NB-1:0] diff_s;
    logic          step_fwd_s;
    logic          terminal_s;

    // The index slice must fit inside the position word.
    if (CPR_LOG2 < 1 || CPR_LOG2 > NB) begin : g_cpr_range
        $error("qencoder_gen: CPR_LOG2 must be in 1..NB");
    end

    // Gray phase for a position count: 0:00, 1:10, 2:11, 3:01.
    function automatic logic [1:0] phase_of(input logic [1:0] cnt);
        logic [1:0] ph;
        case (cnt)
            2'd0:    ph = 2'b00;
            2'd1:    ph = 2'b10;
            2'd2:    ph = 2'b11;
            2'd3:    ph = 2'b01;
            default: ph = 2'b00;
        endcase
        return ph;
    endfunction

    // Step-rate and shortest-path direction helpers.
    always_comb begin
        period_eff_s = (i_period == {PW{1'b0}}) ? PW'(1) : i_period;
        diff_s       = target_q - pos_q;
        // MSB clear means the forward path is shorter; the 2^(NB-1) tie goes reverse.
        step_fwd_s   = ~diff_s[NB-1];
        // ">=" so that shrinking the period mid-run fires on the next cycle.
        terminal_s   = (presc_q >= (period_eff_s - PW'(1)));
    end

    // Next-state logic for the move controller.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        // Target capture is independent of i_enable.
        if (i_load) begin
            target_d = i_target;
        end else begin
            target_d = target_q;
        end

        if (i_enable) begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = {PW{1'b0}};
                    if (target_q != pos_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (target_q == pos_q) begin
                        // Retargeted onto the current position: stop silently.
                        state_d = ST_IDLE;
                        presc_d = {PW{1'b0}};
                    end else if (terminal_s) begin
                        presc_d = {PW{1'b0}};
                        dir_d   = step_fwd_s;
                        if (step_fwd_s) begin
                            pos_d = pos_q + NB'(1);
                        end else begin
                            pos_d = pos_q - NB'(1);
                        end
                        if (pos_d == target_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = {PW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
            presc_d = presc_q;
        end

        enc_d  = phase_of(pos_d[1:0]);
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers; reset drives the encoder lines to 00 immediately.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            target_q <= {NB{1'b0}};
            presc_q  <= {PW{1'b0}};
            pos_q    <= {NB{1'b0}};
            enc_q    <= 2'b00;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            presc_q  <= presc_d;
            pos_q    <= pos_d;
            enc_q    <= enc_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef QGEN_INDEX_EN
    logic index_q;

    // Index flag registered alongside the position it describes.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            index_q <= 1'b0;
        end else begin
            index_q <= (pos_d[CPR_LOG2-1:0] == {CPR_LOG2{1'b0}});
        end
    end

    assign o_index = index_q;
`else
    assign o_index = 1'b0;
`endif

    assign o_encoder  = enc_q;
    assign o_position = pos_q;
    assign o_dir      = dir_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_qencoder_gen.sv
// -----------------------------------------------------------------------------
// tb_qencoder_gen -- self-checking bench for qencoder_gen.
// Expected step events (cycle, position, phase, direction) are pushed into a
// scoreboard queue as each move is commanded; the observed step events are
// popped against it. A loopback decoder model tracks the A/B lines.
// -----------------------------------------------------------------------------
module tb_qencoder_gen;

    localparam int NB = 32;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [NB-1:0] i_target;
    logic          i_load;
    logic [PW-1:0] i_period;
    logic [1:0]    o_encoder;
    logic [NB-1:0] o_position;
    logic          o_dir;
    logic          o_busy;
    logic          o_done;
    logic          o_index;

    always #5 clk = ~clk;

    qencoder_gen #(.NB(NB), .PW(PW), .CPR_LOG2(10)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_target   (i_target),
        .i_load     (i_load),
        .i_period   (i_period),
        .o_encoder  (o_encoder),
        .o_position (o_position),
        .o_dir      (o_dir),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_index    (o_index)
    );

    typedef struct {
        int          cyc;
        logic [31:0] pos;
        logic [1:0]  enc;
        logic        dir;
    } step_t;

    int    checks   = 0;
    int    failures = 0;
    step_t exp_q[$];
    step_t obs_q[$];
    int    done_cnt;
    int    done_cyc;
    int    glitch_cnt;
    int    busy_first;

    // Quadrature phase table: count mod 4 -> {A,B}.
    function automatic logic [1:0] ref_phase(input logic [31:0] p);
        logic [1:0] lo;
        lo = p[1:0];
        case (lo)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int dec_idx(input logic [1:0] e);
        case (e)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void push_exp(input int cyc, input logic [31:0] pos, input logic dir);
        step_t s;
        s.cyc = cyc; s.pos = pos; s.enc = ref_phase(pos); s.dir = dir;
        exp_q.push_back(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0; i_load = 1'b0; i_enable = 1'b1; i_target = '0;
        repeat (3) tick();
        i_reset = 1'b1;
    endtask

    // Drives one move (load at cycle 0, optional second load, optional enable
    // gap) and records every observed step event; cycle k = k-th edge after load.
    task automatic run(input int ncyc, input logic [31:0] tgt0, input int ld1_at,
                       input logic [31:0] tgt1, input int off_at, input int off_len);
        logic [31:0] prev_pos;
        logic [1:0]  prev_enc;
        step_t       s;
        obs_q.delete();
        done_cnt = 0; done_cyc = -1; glitch_cnt = 0; busy_first = -1;
        prev_pos = o_position; prev_enc = o_encoder;
        for (int k = 0; k < ncyc; k++) begin
            i_load   = (k == 0) || (k == ld1_at);
            i_target = (k == ld1_at) ? tgt1 : tgt0;
            i_enable = !(off_len > 0 && k >= off_at && k < off_at + off_len);
            tick();
            i_load = 1'b0;
            if (o_position !== prev_pos) begin
                s.cyc = k; s.pos = o_position; s.enc = o_encoder; s.dir = o_dir;
                obs_q.push_back(s);
                if ($countones(o_encoder ^ prev_enc) != 1) glitch_cnt++;
            end else if (o_encoder !== prev_enc) begin
                glitch_cnt++;
            end
            if (o_done === 1'b1) begin done_cnt++; done_cyc = k; end
            if (o_busy === 1'b1 && busy_first < 0) busy_first = k;
            prev_pos = o_position; prev_enc = o_encoder;
        end
        i_enable = 1'b1;
    endtask

    task automatic test_reset();
        i_period = 16'd4;
        do_reset();
        checks++; if (o_encoder !== 2'b00) begin failures++; $display("FAIL reset_enc got=%b exp=00", o_encoder); end
        checks++; if (o_position !== 32'd0) begin failures++; $display("FAIL reset_pos got=%h exp=0", o_position); end
        checks++; if ({o_busy, o_done, o_dir, o_index} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {o_busy, o_done, o_dir, o_index}); end
    endtask

    task automatic test_forward();
        step_t e, o;
        do_reset();
        i_period = 16'd4;
        for (int k = 1; k <= 5; k++) push_exp(4 * k + 1, 32'(k), 1'b1);
        run(30, 32'd5, -1, 32'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL fwd_missing exp pos=%0d cyc=%0d", e.pos, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.pos !== e.pos || o.enc !== e.enc || o.dir !== e.dir) begin
                    failures++; $display("FAIL fwd_step got cyc=%0d pos=%h enc=%b dir=%b exp cyc=%0d pos=%h enc=%b dir=%b", o.cyc, o.pos, o.enc, o.dir, e.cyc, e.pos, e.enc, e.dir);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL fwd_extra got=%0d extra steps exp=0", obs_q.size()); end
        checks++; if (done_cnt != 1 || done_cyc != 21) begin failures++; $display("FAIL fwd_done got cnt=%0d cyc=%0d exp cnt=1 cyc=21", done_cnt, done_cyc); end
        checks++; if (busy_first != 1) begin failures++; $display("FAIL fwd_busy_rise got=%0d exp=1", busy_first); end
        checks++; if (o_busy !== 1'b0 || glitch_cnt != 0) begin failures++; $display("FAIL fwd_end got busy=%b glitches=%0d exp busy=0 glitches=0", o_busy, glitch_cnt); end
    endtask

    task automatic test_same_target();
        // Position is 5 from the previous move; reloading 5 must do nothing.
        run(10, 32'd5, -1, 32'd0, 0, 0);
        checks++; if (obs_q.size() != 0 || done_cnt != 0 || busy_first != -1) begin
            failures++; $display("FAIL same_target got steps=%0d done=%0d busy_first=%0d exp 0 0 -1", obs_q.size(), done_cnt, busy_first);
        end
    endtask

    task automatic test_period_zero();
        step_t e, o;
        do_reset();
        i_period = 16'd0;
        push_exp(2, 32'd1, 1'b1);
        push_exp(3, 32'd2, 1'b1);
        run(8, 32'd2, -1, 32'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL p0_missing exp pos=%0d cyc=%0d", e.pos, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.pos !== e.pos || o.enc !== e.enc || o.dir !== e.dir) begin
                    failures++; $display("FAIL p0_step got cyc=%0d pos=%h enc=%b exp cyc=%0d pos=%h enc=%b", o.cyc, o.pos, o.enc, e.cyc, e.pos, e.enc);
                end
            end
        end
        checks++; if (obs_q.size() != 0 || done_cyc != 3) begin failures++; $display("FAIL p0_end got extra=%0d done_cyc=%0d exp 0 3", obs_q.size(), done_cyc); end
    endtask

    task automatic test_reverse_wrap();
        step_t e, o;
        do_reset();
        i_period = 16'd1;
        push_exp(2, 32'hFFFF_FFFF, 1'b0);
        push_exp(3, 32'hFFFF_FFFE, 1'b0);
        push_exp(4, 32'hFFFF_FFFD, 1'b0);
        run(10, 32'hFFFF_FFFD, -1, 32'd0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rev_missing exp pos=%h cyc=%0d", e.pos, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.pos !== e.pos || o.enc !== e.enc || o.dir !== e.dir) begin
                    failures++; $display("FAIL rev_step got cyc=%0d pos=%h enc=%b dir=%b exp cyc=%0d pos=%h enc=%b dir=%b", o.cyc, o.pos, o.enc, o.dir, e.cyc, e.pos, e.enc, e.dir);
                end
            end
        end
        checks++; if (obs_q.size() != 0 || done_cnt != 1 || done_cyc != 4) begin failures++; $display("FAIL rev_done got extra=%0d cnt=%0d cyc=%0d exp 0 1 4", obs_q.size(), done_cnt, done_cyc); end
    endtask

    task automatic test_retarget();
        step_t e, o;
        do_reset();
        i_period = 16'd8;
        push_exp(9,  32'd1, 1'b1);
        push_exp(17, 32'd2, 1'b1);
        push_exp(25, 32'd3, 1'b1);
        // New target captured at edge 26; prescaler keeps running, so the next step is at 33.
        push_exp(33, 32'd2, 1'b0);
        push_exp(41, 32'd1, 1'b0);
        run(55, 32'd100, 26, 32'd1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rt_missing exp pos=%0d cyc=%0d", e.pos, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.pos !== e.pos || o.enc !== e.enc || o.dir !== e.dir) begin
                    failures++; $display("FAIL rt_step got cyc=%0d pos=%h dir=%b exp cyc=%0d pos=%h dir=%b", o.cyc, o.pos, o.dir, e.cyc, e.pos, e.dir);
                end
            end
        end
        checks++; if (obs_q.size() != 0 || done_cnt != 1 || done_cyc != 41) begin failures++; $display("FAIL rt_done got extra=%0d cnt=%0d cyc=%0d exp 0 1 41", obs_q.size(), done_cnt, done_cyc); end
    endtask

    task automatic test_enable_freeze();
        step_t e, o;
        do_reset();
        i_period = 16'd4;
        push_exp(5, 32'd1, 1'b1);
        // Frozen for edges 7..26 with prescaler at 1: resumes and steps at 29, then 33.
        push_exp(29, 32'd2, 1'b1);
        push_exp(33, 32'd3, 1'b1);
        run(40, 32'd3, -1, 32'd0, 7, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL frz_missing exp pos=%0d cyc=%0d", e.pos, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.pos !== e.pos || o.enc !== e.enc) begin
                    failures++; $display("FAIL frz_step got cyc=%0d pos=%h exp cyc=%0d pos=%h", o.cyc, o.pos, e.cyc, e.pos);
                end
            end
        end
        checks++; if (obs_q.size() != 0 || done_cnt != 1 || done_cyc != 33 || glitch_cnt != 0) begin
            failures++; $display("FAIL frz_end got extra=%0d cnt=%0d cyc=%0d glitch=%0d exp 0 1 33 0", obs_q.size(), done_cnt, done_cyc, glitch_cnt);
        end
    endtask

    task automatic test_reset_mid_step();
        do_reset();
        i_period = 16'd1;
        i_target = 32'd2; i_load = 1'b1;
        tick();
        i_load = 1'b0;
        tick(); tick();
        checks++; if (o_encoder !== 2'b10) begin failures++; $display("FAIL mid_pre got enc=%b exp=10", o_encoder); end
        #2 i_reset = 1'b0;
        #1;
        checks++; if (o_encoder !== 2'b00 || o_position !== 32'd0 || o_busy !== 1'b0) begin
            failures++; $display("FAIL mid_async got enc=%b pos=%h busy=%b exp 00 0 0", o_encoder, o_position, o_busy);
        end
        tick();
        i_reset = 1'b1;
    endtask

    task automatic test_loopback();
        logic [31:0] dec_pos;
        logic [31:0] tgt;
        logic [1:0]  prev_enc;
        int          d;
        bit          finished;
        do_reset();
        dec_pos = 32'd0; prev_enc = o_encoder;
        for (int m = 0; m < 12; m++) begin
            tgt      = o_position + 32'($urandom_range(0, 40)) - 32'd20;
            i_period = 16'($urandom_range(0, 3));
            i_target = tgt; i_load = 1'b1;
            finished = 1'b0;
            for (int c = 0; c < 300 && !finished; c++) begin
                tick();
                i_load = 1'b0;
                d = (dec_idx(o_encoder) - dec_idx(prev_enc)) & 3;
                if (d == 1) dec_pos = dec_pos + 32'd1;
                else if (d == 3) dec_pos = dec_pos - 32'd1;
                prev_enc = o_encoder;
                checks++;
                if (d == 2 || dec_pos !== o_position) begin
                    failures++; $display("FAIL loop_track move=%0d cyc=%0d got pos=%h exp dec=%h d=%0d", m, c, o_position, dec_pos, d);
                end
                if (c >= 1 && o_busy === 1'b0) finished = 1'b1;
            end
            checks++;
            if (!finished || o_position !== tgt) begin
                failures++; $display("FAIL loop_end move=%0d got pos=%h exp=%h finished=%0d", m, o_position, tgt, finished);
            end
        end
    endtask

    initial begin
        i_reset = 1'b0; i_enable = 1'b1; i_load = 1'b0; i_target = '0; i_period = 16'd4;
        test_reset();
        test_forward();
        test_same_target();
        test_period_zero();
        test_reverse_wrap();
        test_retarget();
        test_enable_freeze();
        test_reset_mid_step();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
